// File: rtl/traffic_controller_actuated.sv
// Sensor-actuated two-road intersection controller.
// A tick prescaler drives one phase timer. Main green is held until a latched
// side-road demand arrives. All-red clearance separates every green.
// A commanded blink mode flashes both yellows.
// Optional pedestrian walk signalling is compiled in when PED_WALK_EN is defined.
// Lamp, walk and state outputs are registered.
// Lamps and walk signals are decoded from next-state values, so they stay
// aligned with state_o.
module traffic_controller_actuated #(
    parameter int CNT_W        = 16,
    parameter int TICK_DIV     = 50000,
    parameter int T_MIN_MAIN   = 1500,
    parameter int T_GREEN_SIDE = 1000,
    parameter int T_YELLOW     = 500,
    parameter int T_ALLRED     = 100,
    parameter int T_BLINK      = 250
`ifdef PED_WALK_EN
    , parameter int T_WALK     = 600
`endif
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       side_sense,
    input  logic       blink_req,
    output logic       main_R,
    output logic       main_G,
    output logic       main_Y,
    output logic       side_R,
    output logic       side_G,
    output logic       side_Y,
    output logic [2:0] state_o,
    output logic       req_pending
`ifdef PED_WALK_EN
    , input  logic     ped_btn,
    output logic       ped_walk,
    output logic       ped_dont_walk
`endif
);

    typedef enum logic [2:0] {
        AR_TO_MAIN  = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        AR_TO_SIDE  = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        BLINK       = 3'd6
    } state_t;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] MINMN_END  = CNT_W'(T_MIN_MAIN - 1);
    localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] SGREEN_END = CNT_W'(T_GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] BLINK_END  = CNT_W'(T_BLINK - 1);
    // Lamp vector order: {main_R, main_Y, main_G, side_R, side_Y, side_G}
    localparam logic [5:0] LAMPS_ALLRED = 6'b100_100;

    logic [1:0]       rst_sync_q;
    logic             rst_n_int;
    logic [PRE_W-1:0] pre_q;
    logic             tick;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             blink_q, blink_d;
    logic             blink_toggle;
    logic             req_q, req_d;
    logic             demand;
    logic [5:0]       lamps_q, lamps_d;

    // Reset assertion is immediate; release is delayed by two clocks so that
    // every flop leaves reset on the same edge.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_int = rst_sync_q[1];
    assign tick      = (pre_q == PRE_MAX);

`ifdef PED_WALK_EN
    assign demand = side_sense | ped_btn;
`else
    assign demand = side_sense;
`endif

    // The prescaler wraps at TICK_DIV-1 and produces the one-cycle tick enable.
    always_ff @(posedge clk_50 or negedge rst_n_int) begin
        if (!rst_n_int) pre_q <= '0;
        else if (tick)  pre_q <= '0;
        else            pre_q <= pre_q + PRE_W'(1);
    end

    // Next-state logic. A blink request overrides every state except BLINK.
    always_comb begin
        state_d      = state_q;
        blink_toggle = 1'b0;
        if (blink_req && state_q != BLINK) begin
            state_d = BLINK;
        end else begin
            case (state_q)
                AR_TO_MAIN:  if (tick && timer_q == ALLRED_END) state_d = MAIN_GREEN;
                MAIN_GREEN:  if (tick && timer_q >= MINMN_END && req_q) state_d = MAIN_YELLOW;
                MAIN_YELLOW: if (tick && timer_q == YELLOW_END) state_d = AR_TO_SIDE;
                AR_TO_SIDE:  if (tick && timer_q == ALLRED_END) state_d = SIDE_GREEN;
                SIDE_GREEN:  if (tick && timer_q == SGREEN_END) state_d = SIDE_YELLOW;
                SIDE_YELLOW: if (tick && timer_q == YELLOW_END) state_d = AR_TO_MAIN;
                BLINK: begin
                    if (!blink_req)                         state_d = AR_TO_MAIN;
                    else if (tick && timer_q == BLINK_END)  blink_toggle = 1'b1;
                end
                default:     state_d = BLINK;
            endcase
        end
    end

    // Timer, blink phase, demand latch and lamp decode for the coming state.
    always_comb begin
        timer_d = timer_q;
        blink_d = blink_q;
        req_d   = req_q;
        lamps_d = LAMPS_ALLRED;
        if (state_d != state_q || blink_toggle) timer_d = '0;
        else if (tick && timer_q != '1)         timer_d = timer_q + CNT_W'(1);
        if (state_d == BLINK && state_q != BLINK) blink_d = 1'b1;
        else if (blink_toggle)                    blink_d = ~blink_q;
        if (state_d == SIDE_GREEN && state_q != SIDE_GREEN) req_d = 1'b0;
        if (demand) req_d = 1'b1;
        case (state_d)
            MAIN_GREEN:  lamps_d = 6'b001_100;
            MAIN_YELLOW: lamps_d = 6'b010_100;
            SIDE_GREEN:  lamps_d = 6'b100_001;
            SIDE_YELLOW: lamps_d = 6'b100_010;
            BLINK:       lamps_d = {1'b0, blink_d, 1'b0, 1'b0, blink_d, 1'b0};
            default:     lamps_d = LAMPS_ALLRED;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_50 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= AR_TO_MAIN;
            timer_q <= '0;
            blink_q <= 1'b0;
            req_q   <= 1'b0;
            lamps_q <= LAMPS_ALLRED;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
            req_q   <= req_d;
            lamps_q <= lamps_d;
        end
    end

    assign {main_R, main_Y, main_G, side_R, side_Y, side_G} = lamps_q;
    assign state_o     = state_q;
    assign req_pending = req_q;

`ifdef PED_WALK_EN
    localparam logic [CNT_W-1:0] WALK_LIM = CNT_W'(T_WALK);
    logic walk_q, walk_d;

    assign walk_d = (state_d == SIDE_GREEN) && (timer_d < WALK_LIM);

    // Walk is lit only during the first T_WALK ticks of side green.
    always_ff @(posedge clk_50 or negedge rst_n_int) begin
        if (!rst_n_int) walk_q <= 1'b0;
        else            walk_q <= walk_d;
    end

    assign ped_walk      = walk_q;
    assign ped_dont_walk = ~walk_q;
`endif

endmodule

// File: tb/tb_traffic_controller_actuated.sv
// Directed testbench for traffic_controller_actuated with small timing parameters.
// One tick is four clocks. Outputs are sampled and inputs driven on the falling edge.
// "sample k" means the k-th falling edge after reset_n is released.
module tb_traffic_controller_actuated;

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       side_sense = 1'b0;
    logic       blink_req = 1'b0;
    logic       main_R, main_G, main_Y, side_R, side_G, side_Y;
    logic [2:0] state_o;
    logic       req_pending;
`ifdef PED_WALK_EN
    logic       ped_btn = 1'b0;
    logic       ped_walk, ped_dont_walk;
`endif

    int checks = 0;
    int errors = 0;

    // Lamp vectors: {main_R, main_Y, main_G, side_R, side_Y, side_G}
    localparam logic [5:0] L_AR  = 6'b100_100;
    localparam logic [5:0] L_MG  = 6'b001_100;
    localparam logic [5:0] L_MY  = 6'b010_100;
    localparam logic [5:0] L_SG  = 6'b100_001;
    localparam logic [5:0] L_SY  = 6'b100_010;
    localparam logic [5:0] L_BK1 = 6'b010_010;
    localparam logic [5:0] L_BK0 = 6'b000_000;

    typedef struct {
        int         n;
        logic       sense;
        logic       blink;
        logic [2:0] st;
        logic [5:0] lamps;
        logic       req;
    } vec_t;

    vec_t tbl[$];

    traffic_controller_actuated #(
        .CNT_W(16), .TICK_DIV(4), .T_MIN_MAIN(5), .T_GREEN_SIDE(4),
        .T_YELLOW(3), .T_ALLRED(2), .T_BLINK(2)
`ifdef PED_WALK_EN
        , .T_WALK(2)
`endif
    ) dut (
        .clk_50(clk_50), .reset_n(reset_n), .side_sense(side_sense), .blink_req(blink_req),
        .main_R(main_R), .main_G(main_G), .main_Y(main_Y),
        .side_R(side_R), .side_G(side_G), .side_Y(side_Y),
        .state_o(state_o), .req_pending(req_pending)
`ifdef PED_WALK_EN
        , .ped_btn(ped_btn), .ped_walk(ped_walk), .ped_dont_walk(ped_dont_walk)
`endif
    );

    always #5 clk_50 = ~clk_50;

    // Safety invariant checked on every falling edge.
    always @(negedge clk_50) begin
        int mc, sc;
        mc = int'(main_R) + int'(main_G) + int'(main_Y);
        sc = int'(side_R) + int'(side_G) + int'(side_Y);
        checks++;
        if (mc > 1 || sc > 1 || (state_o != 3'd6 && (main_G | main_Y) && (side_G | side_Y))) begin
            errors++;
            $display("[TB] FAIL safety: lamps %b%b%b/%b%b%b state %0d violate the one-lamp and cross-road rule",
                     main_R, main_Y, main_G, side_R, side_Y, side_G, state_o);
        end
    end

    task automatic add(input int n, input logic s, input logic b, input logic [2:0] st,
                       input logic [5:0] l, input logic r);
        vec_t v;
        v.n = n; v.sense = s; v.blink = b; v.st = st; v.lamps = l; v.req = r;
        tbl.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [2:0] st, input logic [5:0] l,
                               input logic r);
        logic [5:0] act;
        act = {main_R, main_Y, main_G, side_R, side_Y, side_G};
        checks++;
        if (state_o !== st || act !== l || req_pending !== r) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d lamps=%b req=%b, expected state=%0d lamps=%b req=%b",
                     name, state_o, act, req_pending, st, l, r);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        side_sense = v.sense;
        blink_req  = v.blink;
        repeat (v.n) @(negedge clk_50);
    endtask

    // Assert reset at a falling edge, check the reset state, release at a falling edge.
    task automatic doReset();
        reset_n    = 1'b0;
        side_sense = 1'b0;
        blink_req  = 1'b0;
`ifdef PED_WALK_EN
        ped_btn    = 1'b0;
`endif
        repeat (3) @(negedge clk_50);
        checkOutput("in_reset", 3'd0, L_AR, 1'b0);
`ifdef PED_WALK_EN
        checks++;
        if (ped_walk !== 1'b0 || ped_dont_walk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ped_reset: walk=%b dont=%b, expected walk=0 dont=1", ped_walk, ped_dont_walk);
        end
`endif
        reset_n = 1'b1;
    endtask

    task automatic runTable(input string name);
        doReset();
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("%s[%0d]", name, i), tbl[i].st, tbl[i].lamps, tbl[i].req);
        end
        tbl.delete();
    endtask

`ifdef PED_WALK_EN
    task automatic checkPed(input string name, input logic [2:0] st, input logic w);
        checks++;
        if (state_o !== st || ped_walk !== w || ped_dont_walk !== ~w) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d walk=%b dont=%b, expected state=%0d walk=%b dont=%b",
                     name, state_o, ped_walk, ped_dont_walk, st, w, ~w);
        end
    endtask
`endif

    initial begin
        @(negedge clk_50);

        // Scenario 1: no demand, main green holds and demand stays clear.
        add(1, 0, 0, 3'd0, L_AR, 0);
        add(8, 0, 0, 3'd0, L_AR, 0);
        add(1, 0, 0, 3'd1, L_MG, 0);
        add(800, 0, 0, 3'd1, L_MG, 0);
        runTable("idle");

        // Scenario 2: single side pulse, full cycle with exact phase lengths.
        add(10, 0, 0, 3'd1, L_MG, 0);
        add(4,  0, 0, 3'd1, L_MG, 0);
        add(1,  1, 0, 3'd1, L_MG, 1);
        add(14, 0, 0, 3'd1, L_MG, 1);
        add(1,  0, 0, 3'd2, L_MY, 1);
        add(11, 0, 0, 3'd2, L_MY, 1);
        add(1,  0, 0, 3'd3, L_AR, 1);
        add(7,  0, 0, 3'd3, L_AR, 1);
        add(1,  0, 0, 3'd4, L_SG, 0);
        add(15, 0, 0, 3'd4, L_SG, 0);
        add(1,  0, 0, 3'd5, L_SY, 0);
        add(11, 0, 0, 3'd5, L_SY, 0);
        add(1,  0, 0, 3'd0, L_AR, 0);
        add(7,  0, 0, 3'd0, L_AR, 0);
        add(1,  0, 0, 3'd1, L_MG, 0);
        add(40, 0, 0, 3'd1, L_MG, 0);
        runTable("pulse");

        // Scenario 3: continuous demand, re-latched at side green entry.
        add(10, 1, 0, 3'd1, L_MG, 1);
        add(19, 1, 0, 3'd1, L_MG, 1);
        add(1,  1, 0, 3'd2, L_MY, 1);
        add(20, 1, 0, 3'd4, L_SG, 1);
        add(36, 1, 0, 3'd1, L_MG, 1);
        add(19, 1, 0, 3'd1, L_MG, 1);
        add(1,  1, 0, 3'd2, L_MY, 1);
        runTable("hold");

        // Scenario 4: blink from side green, demand kept, exit through all-red.
        add(10, 0, 0, 3'd1, L_MG, 0);
        add(1,  1, 0, 3'd1, L_MG, 1);
        add(40, 0, 0, 3'd4, L_SG, 0);
        add(1,  0, 1, 3'd6, L_BK1, 0);
        add(5,  0, 1, 3'd6, L_BK1, 0);
        add(1,  0, 1, 3'd6, L_BK0, 0);
        add(7,  1, 1, 3'd6, L_BK0, 1);
        add(1,  0, 1, 3'd6, L_BK1, 1);
        add(1,  0, 0, 3'd0, L_AR, 1);
        add(6,  0, 0, 3'd0, L_AR, 1);
        add(1,  0, 0, 3'd1, L_MG, 1);
        runTable("blink");

        // Scenario 5: asynchronous reset between edges in main yellow.
        add(10, 0, 0, 3'd1, L_MG, 0);
        add(1,  1, 0, 3'd1, L_MG, 1);
        add(19, 0, 0, 3'd2, L_MY, 1);
        runTable("async");
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset_now", 3'd0, L_AR, 1'b0);
        @(negedge clk_50);
        checkOutput("async_reset_held", 3'd0, L_AR, 1'b0);

`ifdef PED_WALK_EN
        // Scenario 6: pedestrian button drives a side phase with a short walk.
        doReset();
        repeat (10) @(negedge clk_50);
        checkPed("ped_main", 3'd1, 1'b0);
        ped_btn = 1'b1;
        @(negedge clk_50);
        checkOutput("ped_req", 3'd1, L_MG, 1'b1);
        ped_btn = 1'b0;
        repeat (39) @(negedge clk_50);
        checkPed("ped_walk_start", 3'd4, 1'b1);
        repeat (7) @(negedge clk_50);
        checkPed("ped_walk_last", 3'd4, 1'b1);
        repeat (1) @(negedge clk_50);
        checkPed("ped_walk_end", 3'd4, 1'b0);
        repeat (7) @(negedge clk_50);
        checkPed("ped_side_end", 3'd4, 1'b0);
        repeat (1) @(negedge clk_50);
        checkPed("ped_yellow", 3'd5, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
